sdram_axi_tester: RTL and testbench
===================================

Name: sdram_axi_tester

Overview:
- AXI4 burst master that drives the S00_AXI slave port of sdram_axi (upstream neighbour, alternative to the PS M00_AXI port).
- Fills a configurable SDRAM region with an address-derived pattern using INCR write bursts, then reads it back and compares every beat.
- Reports busy/done/pass, a saturating error count and the first failing address, for LED/button-driven board bring-up.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first word tested; must be aligned to BURST_LEN*4.
- WORDS, 4096, number of 32-bit words tested; must be a multiple of BURST_LEN.
- BURST_LEN, 16, beats per burst (1..256); BURST_LEN*4 must divide 4096 so no burst crosses a 4 KB boundary.
- SEED, 32'hA5C3_0F1E, XOR mask applied to the pattern.

Ports:
- ACLK in 1: single clock for all logic.
- ARST in 1: synchronous, active-high reset.
- start in 1: run request; sampled every cycle.
- m_awvalid/m_awready out/in 1/1: AW handshake.
- m_awaddr out 32, m_awlen out 8, m_awsize out 3, m_awburst out 2: write burst address and attributes.
- m_wvalid/m_wready out/in 1/1: W handshake.
- m_wdata out 32, m_wstrb out 4, m_wlast out 1: write data beat.
- m_bvalid in 1, m_bresp in 2, m_bready out 1: write response.
- m_arvalid/m_arready out/in 1/1: AR handshake.
- m_araddr out 32, m_arlen out 8, m_arsize out 3, m_arburst out 2: read burst address and attributes.
- m_rvalid in 1, m_rdata in 32, m_rresp in 2, m_rlast in 1, m_rready out 1: read data beat.
- busy out 1: a run is in progress.
- done out 1: run finished; sticky until the next accepted start.
- pass out 1: done & (err_count==0).
- err_count out 16: saturating error count.
- first_err_addr out 32: byte address of the first error.

Behaviour:
- Pattern: expected(addr) = addr ^ SEED, where addr is the byte address of the beat.
- Fixed attributes: awlen = arlen = BURST_LEN-1; awsize = arsize = 3'b010; awburst = arburst = 2'b01 (INCR); wstrb = 4'hF.
- Reset: all valid/ready outputs 0, busy=0, done=0, err_count=0, first_err_addr=0, address registers = ADDR_BASE, state IDLE.
- Reset mid-operation takes effect on the next edge and outputs drop immediately. This is acceptable because sdram_axi resets from the same source.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE; start in any other state is ignored.
  - On acceptance: err_count, first_err_addr and done clear; cur_addr = ADDR_BASE; busy=1; next state WR_ADDR. m_awvalid is high on the cycle after start.
- WR_ADDR: m_awvalid=1 with m_awaddr=cur_addr, held stable until m_awready. On the handshake, go to WR_DATA with beat=0.
- WR_DATA (write data is issued only after AW is accepted):
  - m_wvalid is held high; m_wdata = expected(cur_addr + 4*beat); m_wlast = (beat==BURST_LEN-1).
  - The beat advances only on m_wvalid & m_wready.
  - After the last beat, go to WR_RESP.
- WR_RESP: m_bready=1. On m_bvalid:
  - bresp != 2'b00 counts as one error at the burst start address.
  - cur_addr += BURST_LEN*4.
  - If cur_addr reaches ADDR_BASE + WORDS*4, reload cur_addr = ADDR_BASE and go to RD_ADDR; else go to WR_ADDR.
- RD_ADDR: same rules as WR_ADDR on the AR channel, then go to RD_DATA with beat=0.
- RD_DATA: m_rready=1 continuously. Each m_rvalid beat is compared:
  - Error if rdata != expected(cur_addr + 4*beat), or rresp != 0, or rlast != (beat==BURST_LEN-1).
  - At most one error is counted per beat.
  - The burst ends when the beat count reaches BURST_LEN, regardless of rlast. Address advances as in WR_RESP.
  - After the final burst, go to DONE.
- DONE: busy=0, done=1.
- Error bookkeeping:
  - err_count saturates at 16'hFFFF.
  - first_err_addr is captured only when err_count==0 at the time of the error.
  - A read error on the same cycle as a start is impossible, because start is ignored while busy.
- Single outstanding transaction: AW/AR are never issued while a burst is in flight.

Decomposition:
- Package sdram_test_pkg holds:
  - the state_t enum;
  - constants AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00;
  - function pattern(addr, seed).
- No sub-module: the FSM, beat counter and compare logic stay in one module (about 200 lines).

Test Plan:
- WORDS=64, BURST_LEN=16, behavioural AXI RAM, start pulse -> AW addresses 0x00/0x40/0x80/0xC0 each with awlen=15; then 4 AR bursts at the same addresses; done=1, pass=1, err_count=0.
- RAM model flips bit 0 of the word at 0x44 on readback -> err_count=1, first_err_addr=0x44, pass=0.
- Random stalls on awready/wready/bvalid/arready/rvalid (about 50% duty) -> valids and payloads held stable while stalled; pass=1; no duplicated or skipped beats.
- bresp=2'b10 on the second write burst -> err_count=1, first_err_addr=0x40; the read phase still completes.
- start asserted mid-run -> ignored (AW count stays 4); start after done -> err_count/done clear and the run repeats.
- ARST asserted during WR_DATA beat 5 -> next cycle m_wvalid=0, busy=0, err_count=0, state IDLE; a new start runs cleanly.

Source files
------------

// File: rtl/sdram_test_pkg.sv
// sdram_test_pkg: shared states, AXI constants and the test pattern for sdram_axi_tester
package sdram_test_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction
endpackage

// File: rtl/sdram_axi_tester.sv
// sdram_axi_tester: AXI4 burst master that writes an address-derived pattern, reads it back and counts mismatches
module sdram_axi_tester
  import sdram_test_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          WORDS     = 4096,
  parameter int          BURST_LEN = 16,
  parameter logic [31:0] SEED      = 32'hA5C3_0F1E
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        start,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  input  logic        m_bvalid,
  input  logic [1:0]  m_bresp,
  output logic        m_bready,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  output logic        m_rready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr
);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0] END_ADDR    = ADDR_BASE + 32'(WORDS * 4);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  state_t      state_q;
  logic [31:0] cur_addr_q, first_err_addr_q;
  logic [7:0]  beat_q;
  logic [15:0] err_count_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, busy_q, done_q;
  logic [31:0] beat_addr, next_addr, err_addr;
  logic        last_beat, wrap, err_hit;
  assign beat_addr = cur_addr_q + {22'd0, beat_q, 2'b00};
  assign next_addr = cur_addr_q + BURST_BYTES;
  assign wrap      = next_addr == END_ADDR;
  assign last_beat = beat_q == LAST_BEAT;
  // a read beat with several faults still counts once
  assign err_hit   = state_q == WR_RESP ? m_bvalid && m_bresp != AXI_RESP_OKAY
                   : state_q == RD_DATA && m_rvalid &&
                     (m_rdata != pattern(beat_addr, SEED) || m_rresp != AXI_RESP_OKAY || m_rlast != last_beat);
  assign err_addr  = state_q == WR_RESP ? cur_addr_q : beat_addr;
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q          <= IDLE;
      cur_addr_q       <= ADDR_BASE;
      beat_q           <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      bready_q         <= 1'b0;
      arvalid_q        <= 1'b0;
      rready_q         <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q          <= WR_ADDR;
          cur_addr_q       <= ADDR_BASE;
          awvalid_q        <= 1'b1;
          busy_q           <= 1'b1;
          done_q           <= 1'b0;
          err_count_q      <= '0;
          first_err_addr_q <= '0;
        end
        WR_ADDR: if (m_awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          beat_q    <= '0;
          state_q   <= WR_DATA;
        end
        WR_DATA: if (m_wready) begin
          beat_q <= beat_q + 8'd1;
          if (last_beat) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (m_bvalid) begin
          bready_q   <= 1'b0;
          cur_addr_q <= wrap ? ADDR_BASE : next_addr;
          arvalid_q  <= wrap;
          awvalid_q  <= !wrap;
          state_q    <= wrap ? RD_ADDR : WR_ADDR;
        end
        RD_ADDR: if (m_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          beat_q    <= '0;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (m_rvalid) begin
          beat_q <= beat_q + 8'd1;
          if (last_beat) begin
            rready_q   <= 1'b0;
            cur_addr_q <= wrap ? cur_addr_q : next_addr;
            arvalid_q  <= !wrap;
            busy_q     <= !wrap;
            done_q     <= wrap;
            state_q    <= wrap ? DONE : RD_ADDR;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (err_hit) begin
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
        if (err_count_q == 16'd0) first_err_addr_q <= err_addr;
      end
    end
  end
  assign m_awvalid      = awvalid_q;
  assign m_awaddr       = cur_addr_q;
  assign m_awlen        = LAST_BEAT;
  assign m_awsize       = AXI_SIZE_4B;
  assign m_awburst      = AXI_BURST_INCR;
  assign m_wvalid       = wvalid_q;
  assign m_wdata        = pattern(beat_addr, SEED);
  assign m_wstrb        = 4'hF;
  assign m_wlast        = last_beat;
  assign m_bready       = bready_q;
  assign m_arvalid      = arvalid_q;
  assign m_araddr       = cur_addr_q;
  assign m_arlen        = LAST_BEAT;
  assign m_arsize       = AXI_SIZE_4B;
  assign m_arburst      = AXI_BURST_INCR;
  assign m_rready       = rready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && err_count_q == 16'd0;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
endmodule

// File: tb/tb_sdram_axi_tester.sv
// tb_sdram_axi_tester: directed bench with a behavioural AXI RAM slave for sdram_axi_tester
module tb_sdram_axi_tester;
  import sdram_test_pkg::*;
  localparam logic [31:0] SEED = 32'hA5C3_0F1E;
  logic ACLK = 1'b0, ARST = 1'b1, start = 1'b0;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready, busy, done, pass;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata, first_err_addr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize;
  logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic [3:0] m_wstrb;
  logic [15:0] err_count;
  always #5 ACLK = ~ACLK;

  sdram_axi_tester #(.ADDR_BASE(32'h0), .WORDS(64), .BURST_LEN(16), .SEED(SEED)) dut (
    .ACLK(ACLK), .ARST(ARST), .start(start),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  logic [31:0] mem [0:63];
  logic [31:0] aw_log [0:255];
  logic [31:0] ar_log [0:255];
  logic [5:0] wptr, rptr;
  logic [4:0] wbeat, rbeat;
  logic aw_pend, w_done, ar_pend;
  int aw_cnt = 0, ar_cnt = 0, b_cnt = 0, wbeats = 0, rbeats = 0, prot_err = 0, stab_err = 0;
  bit stall = 0, flip_en = 0;
  logic [31:0] flip_addr = 32'h0;
  int bad_b_at = -1;

  function automatic logic rnd();
    return stall ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  always @(posedge ACLK) begin : slave
    logic fire;
    logic [4:0] nb;
    logic [5:0] np;
    if (ARST) begin
      m_awready <= 0; m_wready <= 0; m_bvalid <= 0; m_arready <= 0; m_rvalid <= 0; m_rlast <= 0;
      m_bresp <= 0; m_rresp <= 0; m_rdata <= 0; aw_pend <= 0; w_done <= 0; ar_pend <= 0;
      wbeat <= 0; rbeat <= 0; wptr <= 0; rptr <= 0;
    end else begin
      if (m_awvalid && m_awready) begin
        if (m_awlen != 8'd15 || m_awsize != 3'b010 || m_awburst != 2'b01 || ar_pend) prot_err <= prot_err + 1;
        wptr <= m_awaddr[7:2]; wbeat <= 0; aw_pend <= 1; m_awready <= 0;
        aw_log[aw_cnt] <= m_awaddr; aw_cnt <= aw_cnt + 1;
      end else m_awready <= !aw_pend && rnd();
      m_wready <= rnd();
      if (m_wvalid && m_wready) begin
        if (!aw_pend || w_done || m_wlast != (wbeat == 5'd15) || m_wstrb != 4'hF) prot_err <= prot_err + 1;
        mem[wptr] <= m_wdata; wptr <= wptr + 6'd1; wbeat <= wbeat + 5'd1; wbeats <= wbeats + 1;
        if (m_wlast) w_done <= 1;
      end
      if (m_bvalid && m_bready) begin
        m_bvalid <= 0; aw_pend <= 0; w_done <= 0; b_cnt <= b_cnt + 1;
      end else if (w_done && !m_bvalid && rnd()) begin
        m_bvalid <= 1; m_bresp <= (b_cnt == bad_b_at) ? 2'b10 : 2'b00;
      end
      if (m_arvalid && m_arready) begin
        if (m_arlen != 8'd15 || m_arsize != 3'b010 || m_arburst != 2'b01 || aw_pend) prot_err <= prot_err + 1;
        rptr <= m_araddr[7:2]; rbeat <= 0; ar_pend <= 1; m_arready <= 0;
        ar_log[ar_cnt] <= m_araddr; ar_cnt <= ar_cnt + 1;
      end else m_arready <= !ar_pend && rnd();
      fire = m_rvalid && m_rready;
      nb = fire ? rbeat + 5'd1 : rbeat;
      np = fire ? rptr + 6'd1 : rptr;
      if (fire) begin rbeat <= nb; rptr <= np; rbeats <= rbeats + 1; end
      if (ar_pend && (!m_rvalid || fire)) begin
        if (nb == 5'd16) begin m_rvalid <= 0; ar_pend <= 0; end
        else if (rnd()) begin
          m_rvalid <= 1; m_rlast <= nb == 5'd15;
          m_rdata <= mem[np] ^ {31'd0, flip_en && {24'd0, np, 2'b00} == flip_addr};
        end else m_rvalid <= 0;
      end
    end
  end

  logic pav, par, pwv, pwr, pwl, parv, parr;
  logic [31:0] paa, pwd, para;
  always @(posedge ACLK) begin
    if (ARST) begin
      pav <= 0; pwv <= 0; parv <= 0;
    end else begin
      if (pav && !par && (!m_awvalid || m_awaddr != paa)) stab_err <= stab_err + 1;
      if (pwv && !pwr && (!m_wvalid || m_wdata != pwd || m_wlast != pwl)) stab_err <= stab_err + 1;
      if (parv && !parr && (!m_arvalid || m_araddr != para)) stab_err <= stab_err + 1;
      pav <= m_awvalid; par <= m_awready; paa <= m_awaddr;
      pwv <= m_wvalid; pwr <= m_wready; pwd <= m_wdata; pwl <= m_wlast;
      parv <= m_arvalid; parr <= m_arready; para <= m_araddr;
    end
  end

  int checks = 0, passed = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000 && done !== 1'b1; i++) @(negedge ACLK);
    chk({tag, " done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int a0, r0, w0, rb0;
    tick(3);
    ARST = 1'b0;
    tick(1);
    chk("rst awvalid", 32'(m_awvalid), 0);
    chk("rst wvalid", 32'(m_wvalid), 0);
    chk("rst arvalid", 32'(m_arvalid), 0);
    chk("rst bready", 32'(m_bready), 0);
    chk("rst rready", 32'(m_rready), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err_count", 32'(err_count), 0);
    chk("rst first_err_addr", first_err_addr, 0);
    chk("rst awaddr", m_awaddr, 32'h0);
    chk("rst state", 32'(dut.state_q), 32'(IDLE));
    // clean run
    a0 = aw_cnt; r0 = ar_cnt;
    pulse_start();
    chk("run1 awvalid after start", 32'(m_awvalid), 1);
    chk("run1 busy", 32'(busy), 1);
    wait_done("run1");
    chk("run1 aw count", 32'(aw_cnt - a0), 4);
    chk("run1 ar count", 32'(ar_cnt - r0), 4);
    for (int i = 0; i < 4; i++) begin
      chk("run1 awaddr", aw_log[a0 + i], 32'(i * 64));
      chk("run1 araddr", ar_log[r0 + i], 32'(i * 64));
    end
    chk("run1 awlen", 32'(m_awlen), 15);
    chk("run1 pass", 32'(pass), 1);
    chk("run1 busy", 32'(busy), 0);
    chk("run1 err_count", 32'(err_count), 0);
    chk("run1 mem 0x44", mem[17], 32'hA5C3_0F5A);
    chk("run1 mem 0xFC", mem[63], 32'hA5C3_0FE2);
    // corrupted readback at 0x44
    flip_addr = 32'h44; flip_en = 1;
    pulse_start();
    wait_done("flip");
    flip_en = 0;
    chk("flip err_count", 32'(err_count), 1);
    chk("flip first_err_addr", first_err_addr, 32'h44);
    chk("flip pass", 32'(pass), 0);
    // restart after done clears bookkeeping
    pulse_start();
    chk("restart done", 32'(done), 0);
    chk("restart err_count", 32'(err_count), 0);
    chk("restart first_err_addr", first_err_addr, 0);
    chk("restart busy", 32'(busy), 1);
    wait_done("restart");
    chk("restart pass", 32'(pass), 1);
    // random stalls on all slave handshakes
    stall = 1; w0 = wbeats; rb0 = rbeats;
    pulse_start();
    wait_done("stall");
    stall = 0;
    chk("stall pass", 32'(pass), 1);
    chk("stall write beats", 32'(wbeats - w0), 64);
    chk("stall read beats", 32'(rbeats - rb0), 64);
    chk("stall stability", 32'(stab_err), 0);
    chk("protocol", 32'(prot_err), 0);
    // SLVERR on the second write burst
    bad_b_at = b_cnt + 1; r0 = ar_cnt;
    pulse_start();
    wait_done("bresp");
    bad_b_at = -1;
    chk("bresp err_count", 32'(err_count), 1);
    chk("bresp first_err_addr", first_err_addr, 32'h40);
    chk("bresp ar count", 32'(ar_cnt - r0), 4);
    // start while busy is ignored
    a0 = aw_cnt;
    pulse_start();
    tick(20);
    pulse_start();
    tick(30);
    pulse_start();
    wait_done("midstart");
    tick(5);
    chk("midstart aw count", 32'(aw_cnt - a0), 4);
    chk("midstart pass", 32'(pass), 1);
    // reset during write beat 5
    w0 = wbeats;
    pulse_start();
    for (int i = 0; i < 200 && wbeats - w0 < 5; i++) @(negedge ACLK);
    chk("arst beats before reset", 32'(wbeats - w0), 5);
    chk("arst wvalid before reset", 32'(m_wvalid), 1);
    ARST = 1'b1;
    @(negedge ACLK);
    chk("arst wvalid", 32'(m_wvalid), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst err_count", 32'(err_count), 0);
    chk("arst state", 32'(dut.state_q), 32'(IDLE));
    ARST = 1'b0;
    tick(1);
    pulse_start();
    wait_done("post-arst");
    chk("post-arst pass", 32'(pass), 1);
    chk("post-arst stability", 32'(stab_err), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
